// File: rtl/regfile_operand_fetch.sv
// rtl/regfile_operand_fetch.sv - ARM64 register file with bypassed read and ID/EX operand latch
//
// Purpose: holds X0..X30 (X31 reads as zero), accepts writes from the
//   writeback stage, reads the two decode sources with a same-cycle WB->ID
//   bypass, and registers them into the ID/EX latch with stall/flush control.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   wb_RegWrite/wb_write_reg/_data    writeback write port
//   id_valid/id_rn/id_rm              decode slot and source indices
//   stall, flush                      ID/EX latch control (flush wins)
//   ex_valid/ex_rn/ex_rm              latched instruction valid and indices
//   ex_rn_data/ex_rm_data             latched operands
module regfile_operand_fetch #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_RegWrite,
  input  logic [4:0]       wb_write_reg,
  input  logic [WIDTH-1:0] wb_write_data,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [4:0]       ex_rn,
  output logic [4:0]       ex_rm,
  output logic [WIDTH-1:0] ex_rn_data,
  output logic [WIDTH-1:0] ex_rm_data
);

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd_rn;
  logic [WIDTH-1:0] rd_rm;
  logic             wr_en;
  logic             refresh_rn;
  logic             refresh_rm;

  // Writes to the zero register are dropped entirely.
  assign wr_en = wb_RegWrite && (wb_write_reg != ZR);

  // Read with bypass: a write landing this cycle is visible to decode now.
  always_comb begin
    rd_rn = regs[id_rn];
    rd_rm = regs[id_rm];
    if (id_rn == ZR)
      rd_rn = '0;
    else if (wb_RegWrite && wb_write_reg == id_rn)
      rd_rn = wb_write_data;
    if (id_rm == ZR)
      rd_rm = '0;
    else if (wb_RegWrite && wb_write_reg == id_rm)
      rd_rm = wb_write_data;
  end

  // While stalled, a held operand picks up a write to its own source so the
  // instruction does not leave with a stale value.
  assign refresh_rn = wr_en && (wb_write_reg == ex_rn);
  assign refresh_rm = wr_en && (wb_write_reg == ex_rm);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[wb_write_reg] <= wb_write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_rn      <= '0;
      ex_rm      <= '0;
      ex_rn_data <= '0;
      ex_rm_data <= '0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_rn      <= '0;
      ex_rm      <= '0;
      ex_rn_data <= '0;
      ex_rm_data <= '0;
    end else if (stall) begin
      if (refresh_rn)
        ex_rn_data <= wb_write_data;
      if (refresh_rm)
        ex_rm_data <= wb_write_data;
    end else begin
      // Data is captured even for a bubble; downstream ignores it.
      ex_valid   <= id_valid;
      ex_rn      <= id_rn;
      ex_rm      <= id_rm;
      ex_rn_data <= rd_rn;
      ex_rm_data <= rd_rm;
    end
  end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// tb/tb_regfile_operand_fetch.sv - self-checking bench for regfile_operand_fetch
module tb_regfile_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_RegWrite;
  logic [4:0]  wb_write_reg;
  logic [63:0] wb_write_data;
  logic        id_valid;
  logic [4:0]  id_rn;
  logic [4:0]  id_rm;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [4:0]  ex_rn;
  logic [4:0]  ex_rm;
  logic [63:0] ex_rn_data;
  logic [63:0] ex_rm_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural registers and the expected ID/EX contents.
  logic [63:0] m_regs [32];
  logic        m_valid;
  logic [4:0]  m_rn, m_rm;
  logic [63:0] m_rnd, m_rmd;

  always #5 clk = ~clk;

  regfile_operand_fetch #(.WIDTH(64), .NREGS(32), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset),
    .wb_RegWrite(wb_RegWrite), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_rn(ex_rn), .ex_rm(ex_rm),
    .ex_rn_data(ex_rn_data), .ex_rm_data(ex_rm_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'h0;
    m_valid = 1'b0; m_rn = 5'd0; m_rm = 5'd0; m_rnd = 64'h0; m_rmd = 64'h0;
  endtask

  // What decode sees for a source this cycle, including a same-cycle WB write.
  function automatic logic [63:0] m_read(input logic [4:0] src);
    if (src == 5'd31) return 64'h0;
    if (wb_RegWrite && wb_write_reg == src) return wb_write_data;
    return m_regs[src];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".ex_valid"},   64'(ex_valid), 64'(m_valid));
    chk({tag, ".ex_rn"},      64'(ex_rn),    64'(m_rn));
    chk({tag, ".ex_rm"},      64'(ex_rm),    64'(m_rm));
    chk({tag, ".ex_rn_data"}, ex_rn_data,    m_rnd);
    chk({tag, ".ex_rm_data"}, ex_rm_data,    m_rmd);
  endtask

  // One clock: drive inputs, predict the latch and register file, clock, compare.
  task automatic step(input string tag, input logic v, input logic [4:0] rn, input logic [4:0] rm,
                      input logic we, input logic [4:0] wr, input logic [63:0] wd,
                      input logic st, input logic fl);
    logic        n_valid;
    logic [4:0]  n_rn, n_rm;
    logic [63:0] n_rnd, n_rmd;
    id_valid = v; id_rn = rn; id_rm = rm;
    wb_RegWrite = we; wb_write_reg = wr; wb_write_data = wd;
    stall = st; flush = fl;
    n_valid = m_valid; n_rn = m_rn; n_rm = m_rm; n_rnd = m_rnd; n_rmd = m_rmd;
    if (fl) begin
      n_valid = 1'b0; n_rn = 5'd0; n_rm = 5'd0; n_rnd = 64'h0; n_rmd = 64'h0;
    end else if (st) begin
      if (we && wr != 5'd31 && wr == m_rn) n_rnd = wd;
      if (we && wr != 5'd31 && wr == m_rm) n_rmd = wd;
    end else begin
      n_valid = v; n_rn = rn; n_rm = rm; n_rnd = m_read(rn); n_rmd = m_read(rm);
    end
    @(posedge clk);
    #1;
    if (we && wr != 5'd31) m_regs[wr] = wd;
    m_valid = n_valid; m_rn = n_rn; m_rm = n_rm; m_rnd = n_rnd; m_rmd = n_rmd;
    check_all(tag);
  endtask

  initial begin
    logic [4:0] r_rn, r_rm, r_wr;
    reset = 1'b1;
    wb_RegWrite = 1'b0; wb_write_reg = 5'd0; wb_write_data = 64'h0;
    id_valid = 1'b0; id_rn = 5'd0; id_rm = 5'd0; stall = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Source X3 is still zero after reset; X31 is always zero.
    step("t1", 1'b1, 5'd3, 5'd31, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
    chk("t1.rn_zero", ex_rn_data, 64'h0);
    chk("t1.valid", 64'(ex_valid), 64'h1);

    // Write X5, then read it on the following cycle.
    step("t2a", 1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 1'b0);
    step("t2b", 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
    chk("t2.x5", ex_rn_data, 64'hDEAD_BEEF);

    // Same-cycle bypass on both ports, including id_rn == id_rm.
    step("t3", 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 64'h1234, 1'b0, 1'b0);
    chk("t3.bypass_rm", ex_rm_data, 64'h1234);
    chk("t3.bypass_rn", ex_rn_data, 64'h1234);

    // Writes to X31 are dropped and disturb nothing else.
    step("t4a", 1'b1, 5'd31, 5'd5, 1'b1, 5'd31, 64'hFFFF, 1'b0, 1'b0);
    chk("t4.xzr_bypass", ex_rn_data, 64'h0);
    step("t4b", 1'b1, 5'd31, 5'd7, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
    chk("t4.xzr_read", ex_rn_data, 64'h0);
    chk("t4.x7_kept", ex_rm_data, 64'h1234);

    // Stall refresh: hold X9/X5, write X9 during the stall.
    step("t5a", 1'b1, 5'd9, 5'd5, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
    step("t5b", 1'b1, 5'd1, 5'd2, 1'b1, 5'd9, 64'hA5, 1'b1, 1'b0);
    chk("t5.refresh", ex_rn_data, 64'hA5);
    chk("t5.held", ex_rm_data, 64'hDEAD_BEEF);
    chk("t5.held_rn", 64'(ex_rn), 64'd9);

    // Flush beats stall.
    step("t6", 1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1);
    chk("t6.flush_valid", 64'(ex_valid), 64'h0);
    chk("t6.flush_data", ex_rn_data, 64'h0);

    // Randomized traffic, biased towards hazards on the held and decoded sources.
    for (int i = 0; i < 400; i++) begin
      r_rn = 5'($urandom_range(0, 31));
      r_rm = ($urandom_range(0, 3) == 0) ? r_rn : 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: r_wr = m_rn;
        1: r_wr = r_rm;
        default: r_wr = 5'($urandom_range(0, 31));
      endcase
      step("rand", 1'($urandom), r_rn, r_rm, ($urandom_range(0, 2) != 0), r_wr,
           {$urandom, $urandom}, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    // Load something non-zero, then assert reset between clock edges.
    step("pre_rst_a", 1'b0, 5'd0, 5'd0, 1'b1, 5'd12, 64'h55AA, 1'b0, 1'b0);
    step("pre_rst_b", 1'b1, 5'd12, 5'd5, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("rst_hold");
    // Register file contents must also be gone.
    step("post_rst", 1'b1, 5'd12, 5'd5, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
    chk("post_rst.x12", ex_rn_data, 64'h0);
    chk("post_rst.x5", ex_rm_data, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
